// File: rtl/fft_spectrum_frame_ctrl.sv
// Frame sequencer around the FFT-modulus sync FIFO: arms on start, captures one
// SOF-aligned spectrum frame, replays it with index/last, and flushes on resync or abort.
`timescale 1ns/1ps
module fft_spectrum_frame_ctrl #(
  parameter int FRAME_LEN = 1024,
  parameter int DATA_W    = 73,
  parameter int IDX_W     = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              cfg_continuous,
  input  logic              s_valid,
  input  logic              s_sof,
  input  logic [DATA_W-1:0] s_data,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_wr_data,
  input  logic              fifo_wr_full,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic              fifo_rd_empty,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [IDX_W-1:0]  m_index,
  output logic              m_last,
  output logic              busy,
  output logic              frame_done,
  output logic              err_overflow,
  output logic              err_sync,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_READOUT = 3'd3,
    ST_FLUSH   = 3'd4
  } state_t;

  localparam logic [IDX_W-1:0] LP_LAST = IDX_W'(FRAME_LEN - 1);

  if (FRAME_LEN < 2 || FRAME_LEN > 2047 || FRAME_LEN >= (1 << IDX_W)) begin : g_bad_frame_len
    $error("FRAME_LEN must lie in 2..2047 and fit in IDX_W bits");
  end

  state_t              r_state;
  state_t              w_state_next;
  logic [IDX_W-1:0]    r_acc_cnt;
  logic [IDX_W-1:0]    r_wr_cnt;
  logic [IDX_W-1:0]    r_rd_cnt;
  logic                r_inflight;
  logic                r_m_valid;
  logic [DATA_W-1:0]   r_m_data;
  logic [IDX_W-1:0]    r_m_index;
  logic                r_m_last;
  logic                r_frame_done;
  logic                r_err_overflow;
  logic                r_err_sync;
  logic                r_flush_to_arm;

  logic w_wr_en;
  logic w_rd_en;
  logic w_hs;
  logic w_drain_idle;
  logic w_start_ok;
  logic w_sof_arm;
  logic w_beat;
  logic w_resync;
  logic w_load;
  logic w_frame_end;
  logic w_flush_exit;
  logic w_abort_go;

  // Output handshake: a beat transfers on a clk edge where m_valid && m_ready;
  // m_data/m_index/m_last hold while m_valid && !m_ready, and m_valid drops only
  // after a transfer or on abort.
  assign w_hs         = r_m_valid && m_ready;
  assign w_drain_idle = fifo_rd_empty && !r_inflight;
  assign w_load       = (r_state == ST_READOUT) && r_inflight;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_wr_en      = 1'b0;
    w_rd_en      = 1'b0;
    w_start_ok   = 1'b0;
    w_sof_arm    = 1'b0;
    w_beat       = 1'b0;
    w_resync     = 1'b0;
    w_frame_end  = 1'b0;
    w_flush_exit = 1'b0;
    w_abort_go   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_start_ok   = 1'b1;
          w_state_next = ST_ARM;
        end
      end
      ST_ARM: begin
        if (s_valid && s_sof) begin
          w_sof_arm    = 1'b1;
          w_wr_en      = !fifo_wr_full;
          w_state_next = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (s_valid) begin
          if (s_sof) begin
            w_resync     = 1'b1;
            w_state_next = ST_FLUSH;
          end else begin
            w_beat  = 1'b1;
            w_wr_en = !fifo_wr_full;
            if (r_acc_cnt == LP_LAST) begin
              w_state_next = ST_READOUT;
            end
          end
        end
      end
      ST_READOUT: begin
        if (r_wr_cnt == '0) begin
          w_frame_end  = 1'b1;
          w_state_next = cfg_continuous ? ST_ARM : ST_IDLE;
        end else begin
          w_rd_en = !r_inflight && (!r_m_valid || m_ready) && (r_rd_cnt < r_wr_cnt) && !fifo_rd_empty;
          if (w_hs && r_m_last) begin
            w_frame_end  = 1'b1;
            w_state_next = cfg_continuous ? ST_ARM : ST_IDLE;
          end
        end
      end
      ST_FLUSH: begin
        w_rd_en = !fifo_rd_empty;
        if (w_drain_idle) begin
          w_flush_exit = 1'b1;
          w_state_next = r_flush_to_arm ? ST_ARM : ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    // Abort overrides every other action once the controller is active.
    if (abort && r_state != ST_IDLE) begin
      w_abort_go   = 1'b1;
      w_wr_en      = 1'b0;
      w_rd_en      = 1'b0;
      w_state_next = w_drain_idle ? ST_IDLE : ST_FLUSH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc_cnt      <= '0;
      r_wr_cnt       <= '0;
      r_rd_cnt       <= '0;
      r_inflight     <= 1'b0;
      r_m_valid      <= 1'b0;
      r_m_data       <= '0;
      r_m_index      <= '0;
      r_m_last       <= 1'b0;
      r_frame_done   <= 1'b0;
      r_err_overflow <= 1'b0;
      r_err_sync     <= 1'b0;
      r_flush_to_arm <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_inflight   <= w_rd_en;
      if (w_abort_go) begin
        r_m_valid      <= 1'b0;
        r_m_last       <= 1'b0;
        r_flush_to_arm <= 1'b0;
        if (w_drain_idle) begin
          r_acc_cnt <= '0;
          r_wr_cnt  <= '0;
          r_rd_cnt  <= '0;
        end
      end else begin
        if (w_start_ok) begin
          r_err_overflow <= 1'b0;
          r_err_sync     <= 1'b0;
        end
        if (w_sof_arm) begin
          r_acc_cnt <= IDX_W'(1);
          r_wr_cnt  <= fifo_wr_full ? '0 : IDX_W'(1);
          if (fifo_wr_full) begin
            r_err_overflow <= 1'b1;
          end
        end
        if (w_beat) begin
          r_acc_cnt <= r_acc_cnt + 1'b1;
          if (fifo_wr_full) begin
            r_err_overflow <= 1'b1;
          end else begin
            r_wr_cnt <= r_wr_cnt + 1'b1;
          end
        end
        if (w_resync) begin
          r_err_sync     <= 1'b1;
          r_flush_to_arm <= 1'b1;
        end
        if (w_load) begin
          r_m_data  <= fifo_rd_data;
          r_m_valid <= 1'b1;
          r_m_index <= r_rd_cnt;
          r_m_last  <= (r_rd_cnt == r_wr_cnt - 1'b1);
          r_rd_cnt  <= r_rd_cnt + 1'b1;
        end else if (w_hs) begin
          r_m_valid <= 1'b0;
        end
        if (w_frame_end) begin
          r_frame_done <= 1'b1;
          r_m_last     <= 1'b0;
          r_acc_cnt    <= '0;
          r_wr_cnt     <= '0;
          r_rd_cnt     <= '0;
        end
        if (w_flush_exit) begin
          r_acc_cnt <= '0;
          r_wr_cnt  <= '0;
          r_rd_cnt  <= '0;
        end
      end
    end
  end

  assign fifo_wr_en   = w_wr_en;
  assign fifo_wr_data = s_data;
  assign fifo_rd_en   = w_rd_en;
  assign m_valid      = r_m_valid;
  assign m_data       = r_m_data;
  assign m_index      = r_m_index;
  assign m_last       = r_m_last;
  assign busy         = (r_state != ST_IDLE);
  assign frame_done   = r_frame_done;
  assign err_overflow = r_err_overflow;
  assign err_sync     = r_err_sync;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_fft_spectrum_frame_ctrl.sv
// Bench for fft_spectrum_frame_ctrl: queue-based FIFO model, frame-level expected
// beat list pushed per frame, and a negedge monitor that pops and compares.
`timescale 1ns/1ps
module tb_fft_spectrum_frame_ctrl;
  localparam int FL = 8;
  localparam int DW = 73;
  localparam int IW = 11;
  localparam int SW = DW + IW + 1;

  logic          clk;
  logic          rst;
  logic          start;
  logic          abort;
  logic          cfg_continuous;
  logic          s_valid;
  logic          s_sof;
  logic [DW-1:0] s_data;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_wr_data;
  logic          fifo_wr_full;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_rd_empty;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic [IW-1:0] m_index;
  logic          m_last;
  logic          busy;
  logic          frame_done;
  logic          err_overflow;
  logic          err_sync;
  logic [2:0]    dbg_state;

  logic          force_full;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] fifo_pop_word;
  int            fifo_cnt = 0;
  int            wr_total = 0;
  int            rd_total = 0;

  logic [SW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_errors = 0;
  int            done_cnt = 0;
  int            hs_cnt = 0;
  int            ready_mode = 0;
  int            pat_i = 0;
  logic          prev_stall = 1'b0;
  logic          exp_done = 1'b0;
  logic [SW-1:0] prev_word = '0;

  fft_spectrum_frame_ctrl #(.FRAME_LEN(FL), .DATA_W(DW), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_continuous(cfg_continuous),
    .s_valid(s_valid), .s_sof(s_sof), .s_data(s_data),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_wr_full(fifo_wr_full),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_index(m_index), .m_last(m_last),
    .busy(busy), .frame_done(frame_done), .err_overflow(err_overflow), .err_sync(err_sync),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // FIFO model: 2048 deep, read data registered one cycle after rd_en
  assign fifo_rd_empty = (fifo_cnt == 0);
  assign fifo_wr_full  = force_full || (fifo_cnt >= 2048);

  always @(posedge clk) begin
    if (rst) begin
      fifo_q.delete();
      fifo_cnt     <= 0;
      fifo_rd_data <= '0;
    end else begin
      if (fifo_rd_en && !fifo_rd_empty) begin
        fifo_pop_word = fifo_q.pop_front();
        fifo_rd_data <= fifo_pop_word;
        rd_total     <= rd_total + 1;
      end
      if (fifo_wr_en && !fifo_wr_full) begin
        fifo_q.push_back(fifo_wr_data);
        wr_total <= wr_total + 1;
      end
      fifo_cnt <= fifo_cnt + ((fifo_wr_en && !fifo_wr_full) ? 1 : 0)
                           - ((fifo_rd_en && !fifo_rd_empty) ? 1 : 0);
    end
  end

  // consumer ready generator
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: m_ready = 1'b1;
      1: begin
        m_ready = (pat_i == 0 || pat_i == 3);
        pat_i   = (pat_i + 1) % 4;
      end
      2: m_ready = 1'($urandom_range(0, 1));
      default: m_ready = !(m_valid && m_index == IW'(3));
    endcase
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [SW-1:0] cur;
    logic [SW-1:0] exp_w;
    if (rst) begin
      prev_stall = 1'b0;
      exp_done   = 1'b0;
    end else begin
      cur = {m_last, m_index, m_data};
      if (prev_stall && m_valid) check("hold_stable", cur, prev_word);
      if (frame_done || exp_done) check("frame_done_timing", frame_done, exp_done);
      if (frame_done) done_cnt++;
      exp_done = 1'b0;
      if (m_valid && m_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_beat: actual=%0h required=no beat", cur);
        end else begin
          exp_w = exp_q.pop_front();
          check("beat", cur, exp_w);
        end
        if (m_last) exp_done = 1'b1;
      end
      prev_stall = m_valid && !m_ready;
      prev_word  = cur;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [95:0] w;
    w = {$urandom, $urandom, $urandom};
    return w[DW-1:0];
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic sof, input logic [DW-1:0] d, input logic full);
    s_valid    = 1'b1;
    s_sof      = sof;
    s_data     = d;
    force_full = full;
    tick();
    s_valid    = 1'b0;
    s_sof      = 1'b0;
    force_full = 1'b0;
  endtask

  // Expected output of a frame: the beats not dropped, renumbered from 0, last on the final one.
  task automatic send_frame(input int n_junk, input int gap_max, input logic [FL-1:0] drop,
                            input bit seq_data, input int keep_limit);
    logic [DW-1:0] d [FL];
    int n_keep;
    int idx;
    n_keep = FL - $countones(drop);
    idx = 0;
    for (int k = 0; k < FL; k++) begin
      d[k] = seq_data ? DW'(k) : rand_word();
      if (!drop[k]) begin
        if (keep_limit < 0 || idx < keep_limit)
          exp_q.push_back({idx == n_keep - 1, IW'(idx), d[k]});
        idx++;
      end
    end
    for (int j = 0; j < n_junk; j++) beat(1'b0, rand_word(), 1'b0);
    for (int k = 0; k < FL; k++) begin
      beat(k == 0, d[k], drop[k]);
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) tick();
    end
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int c = 0;
    while (done_cnt < target && c < budget) begin
      tick();
      c++;
    end
    check(name, done_cnt, target);
  endtask

  task automatic check_idle_outputs(input string name);
    check(name, {m_valid, m_last, m_index, m_data, fifo_wr_en, fifo_rd_en,
                 frame_done, err_overflow, err_sync, busy}, '0);
  endtask

  initial begin
    int w0, r0, d0, h0, c;
    logic [FL-1:0] drop;
    rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_continuous = 1'b0;
    s_valid = 1'b0; s_sof = 1'b0; s_data = '0; force_full = 1'b0;
    repeat (3) tick();
    check_idle_outputs("reset_state");
    rst = 1'b0;
    tick();

    // basic frame: 3 junk beats then data 0..7
    ready_mode = 0;
    w0 = wr_total; d0 = done_cnt; h0 = hs_cnt;
    pulse_start();
    send_frame(3, 0, '0, 1'b1, -1);
    wait_done(d0 + 1, 200, "basic_done");
    check("basic_writes", wr_total - w0, 8);
    check("basic_handshakes", hs_cnt - h0, 8);
    check("basic_busy", busy, 1'b0);
    check("basic_errs", {err_overflow, err_sync}, 2'b00);

    // backpressure 1,0,0,1
    ready_mode = 1; pat_i = 0;
    d0 = done_cnt; h0 = hs_cnt;
    pulse_start();
    send_frame(1, 1, '0, 1'b0, -1);
    wait_done(d0 + 1, 300, "bp_done");
    check("bp_handshakes", hs_cnt - h0, 8);

    // overflow on beats 3 and 4
    ready_mode = 2;
    w0 = wr_total; d0 = done_cnt; h0 = hs_cnt;
    pulse_start();
    send_frame(1, 0, 8'h18, 1'b0, -1);
    wait_done(d0 + 1, 300, "ovf_done");
    check("ovf_err", err_overflow, 1'b1);
    check("ovf_writes", wr_total - w0, 6);
    check("ovf_handshakes", hs_cnt - h0, 6);

    // resync: SOF on capture beat 5
    ready_mode = 0;
    pulse_start();
    check("start_clears_errs", {err_overflow, err_sync}, 2'b00);
    w0 = wr_total; r0 = rd_total; d0 = done_cnt;
    beat(1'b1, rand_word(), 1'b0);
    for (int k = 1; k < 5; k++) beat(1'b0, rand_word(), 1'b0);
    beat(1'b1, rand_word(), 1'b0);
    check("resync_err_sync", err_sync, 1'b1);
    repeat (20) tick();
    check("resync_writes", wr_total - w0, 5);
    check("resync_flush_reads", rd_total - r0, 5);
    check("resync_rearmed_busy", busy, 1'b1);
    check("resync_no_done", done_cnt - d0, 0);
    send_frame(2, 0, '0, 1'b0, -1);
    wait_done(d0 + 1, 200, "resync_next_frame_done");
    check("resync_err_sticky", err_sync, 1'b1);

    // continuous: two frames, then abort at index 3
    cfg_continuous = 1'b1;
    ready_mode = 2;
    d0 = done_cnt;
    pulse_start();
    send_frame(2, 1, '0, 1'b0, -1);
    wait_done(d0 + 1, 300, "cont_done_1");
    check("cont_rearmed_busy", busy, 1'b1);
    send_frame(0, 0, '0, 1'b0, -1);
    wait_done(d0 + 2, 300, "cont_done_2");
    ready_mode = 3;
    send_frame(0, 0, '0, 1'b0, 3);
    c = 0;
    while (!(m_valid && m_index == IW'(3)) && c < 200) begin
      tick();
      c++;
    end
    check("abort_reach_index3", {m_valid, m_index}, {1'b1, IW'(3)});
    tick();
    r0 = rd_total; d0 = done_cnt;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_mvalid_drop", m_valid, 1'b0);
    c = 0;
    while (busy && c < 100) begin
      tick();
      c++;
    end
    check("abort_idle", busy, 1'b0);
    check("abort_flush_reads", rd_total - r0, 4);
    repeat (3) tick();
    check("abort_no_done", done_cnt - d0, 0);
    cfg_continuous = 1'b0;
    ready_mode = 0;

    // reset mid-capture at beat 4
    pulse_start();
    beat(1'b1, rand_word(), 1'b0);
    for (int k = 1; k < 4; k++) beat(1'b0, rand_word(), 1'b0);
    rst = 1'b1; s_valid = 1'b1; s_data = rand_word();
    tick();
    check_idle_outputs("reset_mid_capture");
    s_valid = 1'b0; rst = 1'b0;
    tick();
    check("reset_fifo_cleared", fifo_cnt, 0);
    w0 = wr_total; d0 = done_cnt; h0 = hs_cnt;
    pulse_start();
    send_frame(3, 0, '0, 1'b1, -1);
    wait_done(d0 + 1, 200, "post_reset_done");
    check("post_reset_writes", wr_total - w0, 8);
    check("post_reset_handshakes", hs_cnt - h0, 8);

    // randomized frames
    for (int i = 0; i < 4; i++) begin
      drop = '0;
      for (int j = 0; j < 2; j++)
        if ($urandom_range(0, 1) == 1) drop[$urandom_range(0, FL - 1)] = 1'b1;
      ready_mode = 2;
      d0 = done_cnt;
      pulse_start();
      send_frame($urandom_range(0, 3), 2, drop, 1'b0, -1);
      wait_done(d0 + 1, 400, "rand_done");
      check("rand_err_overflow", err_overflow, drop != '0);
    end

    repeat (5) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
